lsu_align: RTL and testbench
============================

# lsu_align

Parametrised load/store alignment unit between the core's memory stage and the data bus. It accepts one load or store per handshake, generates byte strobes and lane-shifted write data, and sign/zero-extends read data. It also handles accesses that straddle a bus-word boundary by issuing two bus beats and merging the results. It supersedes the combinational load/store extension helpers and works at `XLEN` 32 or 64.

## Interface
- `XLEN`, 32: data width; 32 or 64. `NB = XLEN/8` byte lanes.
- `ADDR_W`, 32: address width.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: byte address.
- `req_size` in 2: log2 bytes (0 byte, 1 half, 2 word, 3 double; 3 legal only when XLEN=64).
- `req_signed` in 1: sign-extend load result.
- `req_wdata` in XLEN: store data, right-justified.
- `bus_valid` out 1: bus beat request.
- `bus_ready` in 1: beat completes this cycle; read data valid in the same cycle.
- `bus_wr` out 1: beat is a write.
- `bus_addr` out ADDR_W: word-aligned address (low log2(NB) bits zero).
- `bus_wstrb` out NB: byte-lane enables; reads drive the lanes needed.
- `bus_wdata` out XLEN: lane-positioned write data.
- `bus_rdata` in XLEN: read data.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `resp_err` out 1: access rejected; valid with `resp_valid`.

## Operation
- Request fields are captured on `req_valid && req_ready`.
- The unit computes `off = addr[log2(NB)-1:0]` and `bytes = 1<<size`.
- An access crosses a word boundary when `off + bytes > NB`.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE → BEAT0 on accept. If the access is illegal, IDLE → RESP with `resp_err=1` and no bus beat.
  - BEAT0: `bus_addr = addr & ~(NB-1)`. `bus_wstrb` covers lanes off..min(off+bytes,NB)-1. `bus_wdata = wdata << 8*off`.
    - On `bus_ready`, bytes from lanes off..NB-1 are latched.
    - The next state is BEAT1 if the access crosses, otherwise RESP.
  - BEAT1: `bus_addr` = BEAT0 address + NB, modulo 2^ADDR_W, so the address wraps at the top of the space. `bus_wstrb` covers lanes 0..off+bytes-NB-1. `bus_wdata = wdata >> 8*(NB-off)`. On `bus_ready` → RESP.
  - RESP: `resp_valid=1` for exactly one cycle, then → IDLE.
- Load merge: result byte i = beat0 lane (off+i) when off+i < NB, else beat1 lane (off+i-NB). Bytes at or above `bytes` are zero. If `req_signed`, they are filled with bit 8*bytes-1.
- `bus_valid`, `bus_wr`, `bus_addr`, `bus_wstrb` and `bus_wdata` are registered. They stay stable while `bus_valid && !bus_ready`.
- Misalignment within one word (e.g. half at off=1) always completes in a single beat.
- An illegal size (3 with XLEN=32) always produces `resp_err`.

## Timing
- Reset values: `req_ready=1`; `bus_valid=0`, `bus_wr=0`, `bus_addr=0`, `bus_wstrb=0`, `bus_wdata=0`; `resp_valid=0`, `resp_rdata=0`, `resp_err=0`; state IDLE.
- Accept in cycle 0 → `bus_valid` high in cycle 1.
  - With `bus_ready` in cycle 1, `resp_valid` is in cycle 2 (aligned latency 2).
  - A split access adds one cycle per beat; minimum latency is 3.
  - Each bus-stall cycle adds one cycle.
- No backpressure on the response. The next request is accepted in the cycle after RESP.
- Reset asserted mid-access drops `bus_valid` immediately and discards the access. No response is issued.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined: boundary-crossing accesses are split into two beats as above.
- `LSU_MISALIGN_SPLIT_EN` undefined: boundary-crossing accesses are treated as illegal. They go to RESP with `resp_err=1` and no bus activity. BEAT1 and the merge logic are not built.

## Structure
- The shared package `lsu_pkg` holds:
  - the size encoding constants;
  - the FSM state enum;
  - a function returning the NB-bit strobe mask from (off, bytes).
- Sub-module `lsu_lane_merge`: combinational. It takes the two latched beats, `off`, `size` and `signed`, and produces the extended result. The FSM and registers stay in `lsu_align`.

## Test plan
All scenarios use XLEN=32.
- Load byte at 0x1003, signed, `bus_rdata=0x80000000` → one beat at 0x1000 with strobe 1000; `resp_rdata=0xFFFFFF80`. The same load unsigned → 0x00000080.
- Store word 0xDEADBEEF to 0x2000, `bus_ready` immediate → single beat with addr 0x2000, strobe 1111, data 0xDEADBEEF; `resp_valid` in cycle 2.
- Store half 0x1234 to 0x2003 (split enabled) → beat0: addr 0x2000, strobe 1000, data 0x34000000. Beat1: addr 0x2004, strobe 0001, data 0x00000012.
- Load word at 0x3002, beat0 rdata 0xAABBCCDD, beat1 rdata 0x11223344 → `resp_rdata=0x3344AABB`.
- Hold `bus_ready` low for 3 cycles → bus outputs stable throughout and `resp_valid` delayed by 3 cycles. Then assert `rst` during BEAT0 → `bus_valid=0` immediately, no `resp_valid`, and `req_ready=1` after release.
- Split disabled: load word at 0x3002 → `resp_valid` with `resp_err=1` and `resp_rdata=0` in cycle 1; `bus_valid` never asserted.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store alignment unit.
// Holds the access-size codes, the alignment FSM state type and the
// byte-strobe mask helper used by lsu_align and lsu_lane_merge.
package lsu_pkg;

  // Access size codes: log2 of the access width in bytes.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // Widest bus supported (XLEN=64). Masks are built at this width and
  // callers keep only their low NB bits.
  localparam int MAX_NB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Lanes [off, off+cnt) set. Lanes past the real bus width are dropped
  // by the caller's truncation, which clips the run at the word boundary.
  function automatic logic [MAX_NB-1:0] strb_mask(input logic [3:0] off,
                                                  input logic [3:0] cnt);
    logic [MAX_NB-1:0] m;
    logic [4:0]        lo;
    logic [4:0]        hi;
    lo = {1'b0, off};
    hi = {1'b0, off} + {1'b0, cnt};
    for (int i = 0; i < MAX_NB; i++) begin
      m[i] = (5'(i) >= lo) && (5'(i) < hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// lsu_lane_merge: combinational load-data merge and extension.
// Takes the two captured bus beats (beat1 is tied to zero when the split
// feature is not built), moves the first requested byte down to lane 0,
// then zero- or sign-extends above the access width.
module lsu_lane_merge import lsu_pkg::*; #(
  parameter  int XLEN  = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [XLEN-1:0]  beat0,
  input  logic [XLEN-1:0]  beat1,
  input  logic [OFF_W-1:0] off,
  input  logic [1:0]       size,
  input  logic             sgn,
  output logic [XLEN-1:0]  result
);

  logic [XLEN-1:0] aligned;
  logic [XLEN-1:0] keep;
  logic            fill;

  // Byte i comes from beat0 lane off+i, or beat1 lane off+i-NB once past the top.
  always_comb begin
    aligned = XLEN'({beat1, beat0} >> {off, 3'b000});
    keep    = '1;
    fill    = 1'b0;
    case (size)
      SIZE_B: begin
        keep = XLEN'(8'hFF);
        fill = sgn & aligned[7];
      end
      SIZE_H: begin
        keep = XLEN'(16'hFFFF);
        fill = sgn & aligned[15];
      end
      SIZE_W: begin
        keep = XLEN'(64'h0000_0000_FFFF_FFFF);
        fill = sgn & aligned[31];
      end
      default: begin
        keep = '1;
        fill = 1'b0;
      end
    endcase
    result = (aligned & keep) | ({XLEN{fill}} & ~keep);
  end

endmodule

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the memory stage and the bus.
// One request per handshake; produces byte strobes, lane-shifted store data
// and extended load data. Accesses that cross a bus-word boundary take two
// beats when LSU_MISALIGN_SPLIT_EN is defined; without it they are rejected
// with resp_err and the second-beat path is not built.
module lsu_align import lsu_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN/8-1:0] bus_wstrb,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_e        state_q, state_d;
  logic              wr_q, wr_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   beat0_q, beat0_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_wr_q, bus_wr_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [NB-1:0]     bus_wstrb_q, bus_wstrb_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic              bus_idle;
  logic [XLEN-1:0]   merge_b1;
  logic [XLEN-1:0]   merged;

  // Request decode, evaluated combinationally from the request port.
  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_bytes;
  logic [4:0]        req_end;
  logic              req_cross;
  logic              req_illegal;
  logic [ADDR_W-1:0] req_waddr;
  logic [NB-1:0]     req_strb;
  logic [XLEN-1:0]   req_wdata_sh;

  assign req_off      = req_addr[OFF_W-1:0];
  assign req_bytes    = 4'd1 << req_size;
  assign req_end      = 5'(req_off) + 5'(req_bytes);
  assign req_cross    = req_end > 5'(NB);
  assign req_waddr    = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign req_strb     = NB'(strb_mask(4'(req_off), req_bytes));
  assign req_wdata_sh = req_wdata << {req_off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              cross_q, cross_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   beat1_q, beat1_d;
  logic [3:0]        bytes_q;
  logic [4:0]        end_q;
  logic [3:0]        b1_cnt;
  logic [NB-1:0]     b1_strb;
  logic [OFF_W:0]    b1_rem;
  logic [XLEN-1:0]   b1_wdata;

  // Second beat covers the bytes that spilled past the first word.
  assign bytes_q  = 4'd1 << size_q;
  assign end_q    = 5'(off_q) + 5'(bytes_q);
  assign b1_cnt   = 4'(end_q - 5'(NB));
  assign b1_strb  = NB'(strb_mask(4'd0, b1_cnt));
  assign b1_rem   = (OFF_W+1)'(NB) - {1'b0, off_q};
  assign b1_wdata = wdata_q >> {b1_rem, 3'b000};

  assign req_illegal = ((XLEN == 32) && (req_size == SIZE_D));
  assign merge_b1    = beat1_q;
`else
  assign req_illegal = ((XLEN == 32) && (req_size == SIZE_D)) || req_cross;
  assign merge_b1    = '0;
`endif

  // Next-state, request capture and bus-beat register updates.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    off_d       = off_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    err_d       = err_q;
    beat0_d     = beat0_q;
    bus_valid_d = bus_valid_q;
    bus_wr_d    = bus_wr_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    bus_idle    = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    cross_d     = cross_q;
    wdata_d     = wdata_q;
    beat1_d     = beat1_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          off_d   = req_off;
          size_d  = req_size;
          sgn_d   = req_signed;
          err_d   = req_illegal;
          beat0_d = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          cross_d = req_cross;
          wdata_d = req_wdata;
          beat1_d = '0;
`endif
          if (req_illegal) begin
            state_d = ST_RESP;
          end else begin
            state_d     = ST_BEAT0;
            bus_valid_d = 1'b1;
            bus_wr_d    = req_wr;
            bus_addr_d  = req_waddr;
            bus_wstrb_d = req_strb;
            bus_wdata_d = req_wr ? req_wdata_sh : '0;
          end
        end
      end
      ST_BEAT0: begin
        if (bus_ready) begin
          beat0_d = bus_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (cross_q) begin
            state_d     = ST_BEAT1;
            bus_addr_d  = bus_addr_q + ADDR_W'(NB);
            bus_wstrb_d = b1_strb;
            bus_wdata_d = wr_q ? b1_wdata : '0;
          end else begin
            state_d  = ST_RESP;
            bus_idle = 1'b1;
          end
`else
          state_d  = ST_RESP;
          bus_idle = 1'b1;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_BEAT1: begin
        if (bus_ready) begin
          beat1_d  = bus_rdata;
          state_d  = ST_RESP;
          bus_idle = 1'b1;
        end
      end
`endif
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (bus_idle) begin
      bus_valid_d = 1'b0;
      bus_wr_d    = 1'b0;
      bus_addr_d  = '0;
      bus_wstrb_d = '0;
      bus_wdata_d = '0;
    end
  end

  // State and capture registers; reset drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      err_q       <= 1'b0;
      beat0_q     <= '0;
      bus_valid_q <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q     <= 1'b0;
      wdata_q     <= '0;
      beat1_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      err_q       <= err_d;
      beat0_q     <= beat0_d;
      bus_valid_q <= bus_valid_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q     <= cross_d;
      wdata_q     <= wdata_d;
      beat1_q     <= beat1_d;
`endif
    end
  end

  lsu_lane_merge #(.XLEN(XLEN)) u_merge (
    .beat0  (beat0_q),
    .beat1  (merge_b1),
    .off    (off_q),
    .size   (size_q),
    .sgn    (sgn_q),
    .result (merged)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign bus_valid  = bus_valid_q;
  assign bus_wr     = bus_wr_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_wdata  = bus_wdata_q;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !wr_q && !err_q) ? merged : '0;

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: scoreboard bench for lsu_align at XLEN=32.
// A byte-addressed memory model predicts responses and bus beats; a bus
// slave serves beats from its own memory and checks them; a monitor pops
// expected responses whenever resp_valid is seen.
module tb_lsu_align;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  lsu_align #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int acc; int lat; } exp_t;
  typedef struct { logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; logic wr; int stall; } beat_t;

  exp_t        expq[$];
  beat_t       beatq[$];
  logic [7:0]  mmem [logic [31:0]];
  logic [7:0]  smem [logic [31:0]];
  int          errors = 0;
  int          checks = 0;
  bit          slave_en = 1'b1;
  bit          done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mrd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] srd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : init_byte(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mmem[a + 32'(i)] = w[8*i +: 8];
      smem[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  // Predict the access from byte-level rules, then hand it to the DUT.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata, input int st0, input int st1);
    int          bytes, off, nbeats, n;
    logic        illegal;
    exp_t        e;
    beat_t       b;
    logic [31:0] wa, d, res;
    bytes   = 1 << int'(size);
    off     = int'(addr[1:0]);
    nbeats  = (off + bytes > 4) ? 2 : 1;
    illegal = (size == 2'd3) || (nbeats == 2 && !SPLIT);
    e.lat   = 0;
    e.acc   = 0;
    if (illegal) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else begin
      for (int k = 0; k < nbeats; k++) begin
        wa      = {addr[31:2], 2'b00} + 32'(4 * k);
        b.addr  = wa;
        b.wr    = wr;
        b.strb  = '0;
        b.wdata = '0;
        b.stall = (k == 0) ? st0 : st1;
        for (int j = 0; j < 4; j++) begin
          d = wa + 32'(j) - addr;
          if (d < 32'(bytes)) begin
            b.strb[j]       = 1'b1;
            b.wdata[8*j +: 8] = wdata[8*d +: 8];
          end
        end
        beatq.push_back(b);
      end
      e.err = 1'b0;
      e.lat = nbeats + st0 + ((nbeats == 2) ? st1 : 0);
      if (wr) begin
        for (int i = 0; i < bytes; i++) mmem[addr + 32'(i)] = wdata[8*i +: 8];
        e.rdata = '0;
      end else begin
        res = '0;
        for (int i = 0; i < bytes; i++) res[8*i +: 8] = mrd(addr + 32'(i));
        if (sgn && bytes < 4 && res[8*bytes-1]) begin
          for (int i = bytes; i < 4; i++) res[8*i +: 8] = 8'hFF;
        end
        e.rdata = res;
      end
    end
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_now("req_ready_timeout");
    end else begin
      e.acc = cyc + 1;
      expq.push_back(e);
      req_valid  = 1'b1;
      req_wr     = wr;
      req_addr   = addr;
      req_size   = size;
      req_signed = sgn;
      req_wdata  = wdata;
      @(negedge clk);
      req_valid  = 1'b0;
      req_addr   = $urandom();
      req_wdata  = $urandom();
    end
  endtask

  // Bus slave: checks each beat against the prediction, stalls, serves data.
  initial begin
    beat_t       cur;
    bit          in_beat;
    int          stall_left;
    logic [31:0] s_addr, s_wdata, word;
    logic [3:0]  s_strb;
    logic        s_wr;
    logic [31:0] lmask;
    in_beat    = 1'b0;
    stall_left = 0;
    forever begin
      @(negedge clk);
      bus_ready = 1'b0;
      bus_rdata = $urandom();
      if (slave_en && !rst && bus_valid) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          if (beatq.size() == 0) begin
            fail_now("unexpected_bus_beat");
            stall_left = 0;
          end else begin
            cur = beatq.pop_front();
            lmask = '0;
            for (int j = 0; j < 4; j++) if (cur.strb[j]) lmask[8*j +: 8] = 8'hFF;
            chk("beat_addr", bus_addr, cur.addr);
            chk("beat_strb", 32'(bus_wstrb), 32'(cur.strb));
            chk("beat_wr", 32'(bus_wr), 32'(cur.wr));
            if (cur.wr) chk("beat_wdata", bus_wdata & lmask, cur.wdata);
            stall_left = cur.stall;
          end
          s_addr = bus_addr; s_strb = bus_wstrb; s_wdata = bus_wdata; s_wr = bus_wr;
        end else begin
          chk("stall_addr", bus_addr, s_addr);
          chk("stall_strb", 32'(bus_wstrb), 32'(s_strb));
          chk("stall_wdata", bus_wdata, s_wdata);
          chk("stall_wr", 32'(bus_wr), 32'(s_wr));
        end
        if (stall_left == 0) begin
          for (int j = 0; j < 4; j++) word[8*j +: 8] = srd(bus_addr + 32'(j));
          if (bus_wr) begin
            for (int j = 0; j < 4; j++) if (bus_wstrb[j]) smem[bus_addr + 32'(j)] = bus_wdata[8*j +: 8];
          end
          bus_rdata = word;
          bus_ready = 1'b1;
          in_beat   = 1'b0;
        end else begin
          stall_left--;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every resp_valid.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && !done) begin
        if (bus_valid) chk("ready_while_busy", 32'(req_ready), 32'd0);
        if (resp_valid) begin
          if (expq.size() == 0) begin
            fail_now("unexpected_resp_valid");
          end else begin
            e = expq.pop_front();
            chk("resp_err", 32'(resp_err), 32'(e.err));
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus_wr", 32'(bus_wr), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed accesses.
    preload(32'h0000_1000, 32'h8000_0000);
    issue(1'b0, 32'h0000_1003, 2'd0, 1'b1, 32'h0, 0, 0);
    issue(1'b0, 32'h0000_1003, 2'd0, 1'b0, 32'h0, 0, 0);
    issue(1'b1, 32'h0000_2000, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, 0);
    issue(1'b1, 32'h0000_2003, 2'd1, 1'b0, 32'h0000_1234, 0, 0);
    preload(32'h0000_3000, 32'hAABB_CCDD);
    preload(32'h0000_3004, 32'h1122_3344);
    issue(1'b0, 32'h0000_3002, 2'd2, 1'b0, 32'h0, 0, 0);
    issue(1'b0, 32'h0000_1001, 2'd1, 1'b1, 32'h0, 0, 0);
    issue(1'b0, 32'h0000_1000, 2'd2, 1'b0, 32'h0, 3, 0);
    issue(1'b0, 32'h0000_3003, 2'd1, 1'b1, 32'h0, 2, 3);
    issue(1'b0, 32'h0000_1000, 2'd3, 1'b0, 32'h0, 0, 0);
    issue(1'b1, 32'h0000_1004, 2'd3, 1'b0, 32'h5555_AAAA, 0, 0);
    issue(1'b0, 32'hFFFF_FFFE, 2'd2, 1'b1, 32'h0, 1, 0);

    // Reset in the middle of the first beat.
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    slave_en   = 1'b0;
    req_valid  = 1'b1;
    req_wr     = 1'b0;
    req_addr   = 32'h0000_1000;
    req_size   = 2'd2;
    req_signed = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_bus_valid", 32'(bus_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_bus_valid", 32'(bus_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    slave_en = 1'b1;

    // Randomized traffic, including addresses that wrap past the top.
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = 32'h0000_4000 + 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    n = 0;
    while ((expq.size() != 0 || beatq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) fail_now("responses_outstanding");
    if (beatq.size() != 0) fail_now("bus_beats_outstanding");
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
